// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter
//   Shares one pipelined fpu adder among NREQ requesters. A round-robin
//   arbiter picks one pending requester while idle, the chosen operands are
//   held on the fpu inputs for the adder latency, and the result is presented
//   with the owning requester's index until the consumer accepts it. Only one
//   operation is in flight at a time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid[NREQ]     requester i has operands pending
//   req_ready[NREQ]     one-hot accept strobe (combinational, idle only)
//   req_a/req_b         packed operands, requester i at [32*i+31:32*i]
//   fpu_op_a/fpu_op_b   operands driven to the fpu (held through the job)
//   fpu_data/status     fpu result and flags ([3]EXACT [2]OVF [1]UNF [0]INEXACT)
//   rsp_valid/ready     result handshake toward the consumer
//   rsp_data/status/id  captured result, flags and owning requester index
//   busy                registered (state != IDLE)
//   op_count            completed hand-offs, wraps at 2^CNT_W
module fpu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int FPU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*32-1:0]       req_a,
  input  logic [NREQ*32-1:0]       req_b,
  output logic [31:0]              fpu_op_a,
  output logic [31:0]              fpu_op_b,
  input  logic [31:0]              fpu_data,
  input  logic [3:0]               fpu_status,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [3:0]               rsp_status,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FPU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic             w_gnt_found;
  logic             w_hit;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [3:0]       r_rsp_status;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  // Requester index k positions after p, wrapped into 0..NREQ-1.
  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] p, input int k);
    int t;
    t = int'(p) + k;
    return (t >= NREQ) ? IDW'(t - NREQ) : IDW'(t);
  endfunction

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_hit       = !w_gnt_found && req_valid[f_wrap(r_rr_ptr, k)];
      w_gnt_idx   = w_hit ? f_wrap(r_rr_ptr, k) : w_gnt_idx;
      w_gnt_found = w_gnt_found | w_hit;
    end
    // The winner drops to lowest priority for the next arbitration.
    w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
  end

  // One-hot accept strobe, only ever asserted while idle.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_gnt_found) begin
      req_ready[w_gnt_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_gnt_found ? S_BUSY : S_IDLE;
      S_BUSY:  w_state_nxt = (r_cnt == '0) ? S_RESP : S_BUSY;
      S_RESP:  w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: operand capture, latency countdown, result capture, hand-off count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_op_a       <= 32'd0;
      r_op_b       <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 32'd0;
      r_rsp_status <= 4'd0;
      r_rsp_id     <= '0;
      r_busy       <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_op_a   <= req_a[32*int'(w_gnt_idx) +: 32];
            r_op_b   <= req_b[32*int'(w_gnt_idx) +: 32];
            r_rsp_id <= w_gnt_idx;
            r_rr_ptr <= w_ptr_nxt;
            r_cnt    <= CW'(FPU_LAT);
          end
        end
        S_BUSY: begin
          // The extra cycle beyond FPU_LAT lets the fpu output register settle
          // before it is sampled.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rsp_data   <= fpu_data;
            r_rsp_status <= fpu_status;
            r_rsp_valid  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign fpu_op_a   = r_op_a;
  assign fpu_op_b   = r_op_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: default-parameter instance (4 requesters, 1-cycle
// fpu) plus a 4-bit counter / 3-cycle fpu instance for wrap and latency.
module tb_fpu_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int failures = 0;

  // Instance 0 signals
  logic [3:0]   rv0, rr0;
  logic [127:0] ra0, rb0;
  logic [31:0]  op_a0, op_b0, fd0, rspd0;
  logic [3:0]   fs0, rsps0;
  logic         rspv0, rspr0, busy0;
  logic [1:0]   rspid0;
  logic [15:0]  cnt0;

  // Instance 1 signals
  logic [3:0]   rv1, rr1;
  logic [127:0] ra1, rb1;
  logic [31:0]  op_a1, op_b1, fd1, rspd1;
  logic [3:0]   fs1, rsps1;
  logic         rspv1, rspr1, busy1;
  logic [1:0]   rspid1;
  logic [3:0]   cnt1;

  fpu_req_arbiter #(.NREQ(4), .FPU_LAT(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_a(ra0), .req_b(rb0),
    .fpu_op_a(op_a0), .fpu_op_b(op_b0), .fpu_data(fd0), .fpu_status(fs0),
    .rsp_valid(rspv0), .rsp_ready(rspr0), .rsp_data(rspd0), .rsp_status(rsps0),
    .rsp_id(rspid0), .busy(busy0), .op_count(cnt0));

  fpu_req_arbiter #(.NREQ(4), .FPU_LAT(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_a(ra1), .req_b(rb1),
    .fpu_op_a(op_a1), .fpu_op_b(op_b1), .fpu_data(fd1), .fpu_status(fs1),
    .rsp_valid(rspv1), .rsp_ready(rspr1), .rsp_data(rspd1), .rsp_status(rsps1),
    .rsp_id(rspid1), .busy(busy1), .op_count(cnt1));

  // Single -> double bit conversion (zero/normal only).
  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'd0) return {s[31], 63'd0};
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    return d2s($realtobits(ra + rb));
  endfunction

  // fpu stubs: registered single-precision add, FPU_LAT register stages.
  logic [31:0] p1 [0:2];
  always @(posedge clk) fd0 <= fadd(op_a0, op_b0);
  always @(posedge clk) begin
    p1[0] <= fadd(op_a1, op_b1);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign fd1 = p1[2];
  assign fs0 = 4'b1000;
  assign fs1 = 4'b1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp0(input int maxc, output int n);
    n = 0;
    while (!rspv0 && n < maxc) begin
      step();
      n++;
    end
    if (!rspv0) n = -1;
  endtask

  task automatic wait_rsp1(input int maxc, output int n);
    n = 0;
    while (!rspv1 && n < maxc) begin
      step();
      n++;
    end
    if (!rspv1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rv0 = 4'd0; ra0 = '0; rb0 = '0; rspr0 = 1'b0;
    rv1 = 4'd0; ra1 = '0; rb1 = '0; rspr1 = 1'b0;
    step();
    step();
    checks++;
    if ({busy0, rspv0, rr0, op_a0, op_b0, cnt0} !== '0) begin
      failures++;
      $display("FAIL reset0 busy=%b rspv=%b rr=%b opa=%h opb=%h cnt=%0d exp all 0",
               busy0, rspv0, rr0, op_a0, op_b0, cnt0);
    end
    checks++;
    if ({busy1, rspv1, rspd1, rsps1, rspid1, cnt1} !== '0) begin
      failures++;
      $display("FAIL reset1 busy=%b rspv=%b data=%h st=%b id=%0d cnt=%0d exp all 0",
               busy1, rspv1, rspd1, rsps1, rspid1, cnt1);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    ra0[31:0] = 32'h3F800000;
    rb0[31:0] = 32'h40000000;
    rv0 = 4'b0001;
    #1;
    checks++;
    if (rr0 !== 4'b0001 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL single_grant rr=%b busy=%b exp 0001/0", rr0, busy0);
    end
    step();
    checks++;
    if (busy0 !== 1'b1 || rr0 !== 4'b0000 || op_a0 !== 32'h3F800000 || op_b0 !== 32'h40000000) begin
      failures++;
      $display("FAIL single_busy busy=%b rr=%b opa=%h opb=%h", busy0, rr0, op_a0, op_b0);
    end
    rv0 = 4'd0;
    step();
    checks++;
    if (rspv0 !== 1'b0) begin
      failures++;
      $display("FAIL single_early rsp_valid=%b exp 0 at T+2", rspv0);
    end
    step();
    checks++;
    if (rspv0 !== 1'b1 || rspd0 !== 32'h40400000 || rspid0 !== 2'd0 || rsps0 !== 4'b1000) begin
      failures++;
      $display("FAIL single_rsp v=%b data=%h id=%0d st=%b exp 1/40400000/0/1000",
               rspv0, rspd0, rspid0, rsps0);
    end
    rspr0 = 1'b1;
    step();
    rspr0 = 1'b0;
    checks++;
    if (rspv0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'd1) begin
      failures++;
      $display("FAIL single_handoff v=%b busy=%b cnt=%0d exp 0/0/1", rspv0, busy0, cnt0);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] ta [0:3];
    logic [31:0] tb [0:3];
    logic [31:0] ts [0:3];
    int ord [0:4];
    int ngr, nrsp;
    ta = '{32'h3F800000, 32'h3FC00000, 32'h40800000, 32'h41200000};
    tb = '{32'h40000000, 32'h3F000000, 32'hBF800000, 32'h40C00000};
    ts = '{32'h40400000, 32'h40000000, 32'h40400000, 32'h41800000};
    ord = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra0[32*i +: 32] = ta[i];
      rb0[32*i +: 32] = tb[i];
    end
    rv0 = 4'b1111;
    rspr0 = 1'b1;
    ngr = 0;
    nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 5; c++) begin
      #1;
      checks++;
      if ($countones(rr0) > 1) begin
        failures++;
        $display("FAIL rr_onehot rr=%b exp at most one bit", rr0);
      end
      if (rr0 != 4'd0 && ngr < 5) begin
        checks++;
        if (rr0 !== (4'b0001 << ord[ngr])) begin
          failures++;
          $display("FAIL rr_order grant#%0d rr=%b exp bit %0d", ngr, rr0, ord[ngr]);
        end
        ngr++;
      end
      if (rspv0) begin
        checks++;
        if (rspid0 !== 2'(ord[nrsp]) || rspd0 !== ts[ord[nrsp]]) begin
          failures++;
          $display("FAIL rr_rsp #%0d id=%0d data=%h exp %0d/%h", nrsp, rspid0, rspd0,
                   ord[nrsp], ts[ord[nrsp]]);
        end
        nrsp++;
      end
      step();
    end
    rv0 = 4'd0;
    #1;
    checks++;
    if (nrsp !== 5 || cnt0 !== 16'd5 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL rr_count rsps=%0d op_count=%0d busy=%b exp 5/5/0", nrsp, cnt0, busy0);
    end
    rspr0 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int n;
    ra0[63:32] = 32'h3E800000;
    rb0[63:32] = 32'h3E800000;
    rv0 = 4'b0010;
    #1;
    checks++;
    if (rr0 !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant rr=%b exp 0010", rr0);
    end
    step();
    rv0 = 4'b0001;
    wait_rsp0(10, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL bp_latency cycles=%0d exp 2", n);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rspv0 !== 1'b1 || rspd0 !== 32'h3F000000 || rspid0 !== 2'd1 || rr0 !== 4'd0 || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold c=%0d v=%b data=%h id=%0d rr=%b busy=%b", c, rspv0, rspd0, rspid0, rr0, busy0);
      end
      step();
    end
    rspr0 = 1'b1;
    #1;
    checks++;
    if (rr0 !== 4'd0) begin
      failures++;
      $display("FAIL bp_no_accept_on_handoff rr=%b exp 0000", rr0);
    end
    step();
    rspr0 = 1'b0;
    #1;
    checks++;
    if (rspv0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'd6 || rr0 !== 4'b0001) begin
      failures++;
      $display("FAIL bp_release v=%b busy=%b cnt=%0d rr=%b exp 0/0/6/0001", rspv0, busy0, cnt0, rr0);
    end
    rv0 = 4'd0;
    step();
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_withdrawn busy=%b exp 0", busy0);
    end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    ra0[31:0] = 32'h41200000;
    rb0[31:0] = 32'h40C00000;
    rv0 = 4'b0001;
    step();
    rv0 = 4'd0;
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL rmb_busy busy=%b exp 1", busy0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy0, rspv0, rspd0, rsps0, rspid0, op_a0, op_b0, cnt0} !== '0) begin
      failures++;
      $display("FAIL rmb_cleared busy=%b v=%b data=%h st=%b id=%0d opa=%h opb=%h cnt=%0d exp all 0",
               busy0, rspv0, rspd0, rsps0, rspid0, op_a0, op_b0, cnt0);
    end
    ra0[95:64] = 32'h40800000;
    rb0[95:64] = 32'hBF800000;
    rv0 = 4'b0100;
    #1;
    checks++;
    if (rr0 !== 4'b0100) begin
      failures++;
      $display("FAIL rmb_grant rr=%b exp 0100", rr0);
    end
    step();
    rv0 = 4'd0;
    checks++;
    if (op_a0 !== 32'h40800000 || op_b0 !== 32'hBF800000) begin
      failures++;
      $display("FAIL rmb_operands opa=%h opb=%h exp 40800000/bf800000", op_a0, op_b0);
    end
    wait_rsp0(10, n);
    checks++;
    if (n !== 2 || rspd0 !== 32'h40400000 || rspid0 !== 2'd2) begin
      failures++;
      $display("FAIL rmb_rsp cycles=%0d data=%h id=%0d exp 2/40400000/2", n, rspd0, rspid0);
    end
    rspr0 = 1'b1;
    step();
    rspr0 = 1'b0;
    checks++;
    if (cnt0 !== 16'd1 || rspv0 !== 1'b0) begin
      failures++;
      $display("FAIL rmb_count cnt=%0d v=%b exp 1/0", cnt0, rspv0);
    end
  endtask

  task automatic test_wrap_lat3();
    int n, nh;
    ra1[31:0] = 32'h3F800000;
    rb1[31:0] = 32'h40000000;
    rv1 = 4'b0001;
    #1;
    checks++;
    if (rr1 !== 4'b0001) begin
      failures++;
      $display("FAIL lat3_grant rr=%b exp 0001", rr1);
    end
    step();
    rv1 = 4'd0;
    wait_rsp1(20, n);
    checks++;
    if (n !== 4 || rspd1 !== 32'h40400000 || rsps1 !== 4'b1000) begin
      failures++;
      $display("FAIL lat3_rsp cycles=%0d data=%h st=%b exp 4/40400000/1000", n, rspd1, rsps1);
    end
    rspr1 = 1'b1;
    step();
    checks++;
    if (cnt1 !== 4'd1) begin
      failures++;
      $display("FAIL lat3_count cnt=%0d exp 1", cnt1);
    end
    rv1 = 4'b0001;
    nh = 0;
    for (int c = 0; c < 400 && nh < 16; c++) begin
      step();
      if (rspv1) nh++;
    end
    rv1 = 4'd0;
    step();
    rspr1 = 1'b0;
    checks++;
    if (nh !== 16 || cnt1 !== 4'd1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL wrap jobs=%0d cnt=%0d busy=%b exp 16/1/0", nh, cnt1, busy1);
    end
  endtask

  initial begin
    rst = 1'b1;
    rv0 = 4'd0; ra0 = '0; rb0 = '0; rspr0 = 1'b0;
    rv1 = 4'd0; ra1 = '0; rb1 = '0; rspr1 = 1'b0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_reset_mid_busy();
    test_reset();
    test_wrap_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
